kbd_entry: RTL and testbench

Keypad entry controller that consumes the raw PS/2 scan-code level from the keyboard layer and turns keypad keystrokes into validated HH:MM values for the alarm clock. It detects make events, suppresses break and typematic codes, and accumulates up to four BCD digits. On `*` it commits the entry as a new alarm time; on `-` it commits it as a new clock time. It sits between the PS/2 keyboard receiver and the timekeeping/alarm registers.

---
 rtl/kbd_entry.sv | 174 +++++++++++++++++
 tb/tb_kbd_entry.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_entry.sv
// kbd_entry: keypad entry controller for the alarm clock.
// Turns raw PS/2 set-2 keypad scan codes into BCD HH:MM values. Digits are
// shifted into a four-digit window; '*' commits the window as an alarm time
// and '-' commits it as a clock time, after an hours/minutes range check.
// Optional feature: define KBD_ENTRY_TIMEOUT_EN to discard a partial entry
// after TIMEOUT_CYCLES idle clk256 cycles.

module kbd_entry #(
    parameter int TIMEOUT_CYCLES = 1280
) (
    input  logic        clk256,
    input  logic        reset,
    input  logic [7:0]  key_code,
    output logic [15:0] entry,
    output logic [2:0]  digit_cnt,
    output logic [15:0] new_time,
    output logic        load_time,
    output logic        load_alarm,
    output logic        entry_err
);

    // Set-2 keypad scan codes and the break prefix
    localparam logic [7:0] KP_0      = 8'h70;
    localparam logic [7:0] KP_1      = 8'h69;
    localparam logic [7:0] KP_2      = 8'h72;
    localparam logic [7:0] KP_3      = 8'h7A;
    localparam logic [7:0] KP_4      = 8'h6B;
    localparam logic [7:0] KP_5      = 8'h73;
    localparam logic [7:0] KP_6      = 8'h74;
    localparam logic [7:0] KP_7      = 8'h6C;
    localparam logic [7:0] KP_8      = 8'h75;
    localparam logic [7:0] KP_9      = 8'h7D;
    localparam logic [7:0] KP_STAR   = 8'h7C;
    localparam logic [7:0] KP_MINUS  = 8'h7B;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    // Entry state machine encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ENTRY = 1'b1;

    logic [7:0] key_d;
    logic       brk;
    logic [0:0] state;

    logic       key_event;
    logic       make_evt;
    logic       is_digit;
    logic       is_star;
    logic       is_minus;
    logic [3:0] digit_val;
    logic       entry_valid;
    logic       timeout_hit;

    // A key change is an event; while a break is pending the event is only
    // the released key, so it never counts as a make.
    assign key_event = (key_code != key_d);
    assign make_evt  = key_event && !brk && (key_code != KEY_BREAK);

    // Classify the current scan code as a digit, '*', '-' or anything else
    always_comb begin
        is_digit  = 1'b1;
        is_star   = 1'b0;
        is_minus  = 1'b0;
        digit_val = 4'd0;
        case (key_code)
            KP_0:     digit_val = 4'd0;
            KP_1:     digit_val = 4'd1;
            KP_2:     digit_val = 4'd2;
            KP_3:     digit_val = 4'd3;
            KP_4:     digit_val = 4'd4;
            KP_5:     digit_val = 4'd5;
            KP_6:     digit_val = 4'd6;
            KP_7:     digit_val = 4'd7;
            KP_8:     digit_val = 4'd8;
            KP_9:     digit_val = 4'd9;
            KP_STAR:  begin is_digit = 1'b0; is_star  = 1'b1; end
            KP_MINUS: begin is_digit = 1'b0; is_minus = 1'b1; end
            default:  is_digit = 1'b0;
        endcase
    end

    // Digits are always 0..9, so hours <= 23 reduces to a tens/ones test
    // and minutes <= 59 only depends on the minutes tens digit.
    assign entry_valid = ((entry[15:12] < 4'd2) ||
                          ((entry[15:12] == 4'd2) && (entry[11:8] <= 4'd3))) &&
                         (entry[7:4] <= 4'd5);

`ifdef KBD_ENTRY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;

    // Count idle cycles of a partial entry; any make restarts the count
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (make_evt || (state == ST_IDLE) || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    // Fires on the edge that completes the TIMEOUT_CYCLES-th idle cycle
    assign timeout_hit = (state == ST_ENTRY) && !make_evt &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Track the previous code and the pending-break flag
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            key_d <= 8'h00;
            brk   <= 1'b0;
        end else begin
            key_d <= key_code;
            if (key_event) begin
                if (brk) begin
                    brk <= 1'b0;
                end else if (key_code == KEY_BREAK) begin
                    brk <= 1'b1;
                end
            end
        end
    end

    // Digit accumulation, commit/validate and timeout discard
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            entry      <= 16'h0000;
            digit_cnt  <= 3'd0;
            new_time   <= 16'h0000;
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
            entry_err  <= 1'b0;
        end else begin
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
            entry_err  <= 1'b0;
            if (make_evt && is_digit) begin
                entry <= {entry[11:0], digit_val};
                if (digit_cnt != 3'd4) begin
                    digit_cnt <= digit_cnt + 3'd1;
                end
                state <= ST_ENTRY;
            end else if (make_evt && (is_star || is_minus)) begin
                if (state == ST_IDLE) begin
                    entry_err <= 1'b1;
                end else begin
                    if (entry_valid) begin
                        new_time   <= entry;
                        load_alarm <= is_star;
                        load_time  <= is_minus;
                    end else begin
                        entry_err <= 1'b1;
                    end
                    entry     <= 16'h0000;
                    digit_cnt <= 3'd0;
                    state     <= ST_IDLE;
                end
            end else if (timeout_hit) begin
                entry     <= 16'h0000;
                digit_cnt <= 3'd0;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_kbd_entry.sv
// tb_kbd_entry: scoreboard bench for kbd_entry. A reference model predicts
// the outputs for each driven scan code; predictions are queued and popped
// after the clock edge to compare against the DUT.

module tb_kbd_entry;

    localparam int TB_TIMEOUT = 8;

    logic        clk256;
    logic        reset;
    logic [7:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [15:0] new_time;
    logic        load_time;
    logic        load_alarm;
    logic        entry_err;

    typedef struct {
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] nt;
        logic        lt;
        logic        la;
        logic        er;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  m_prev;
    logic        m_brk;
    logic [15:0] m_entry;
    int          m_cnt;
    logic [15:0] m_new;
    int          m_idle;

    kbd_entry #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk256     (clk256),
        .reset      (reset),
        .key_code   (key_code),
        .entry      (entry),
        .digit_cnt  (digit_cnt),
        .new_time   (new_time),
        .load_time  (load_time),
        .load_alarm (load_alarm),
        .entry_err  (entry_err)
    );

    initial clk256 = 1'b0;
    always #5 clk256 = ~clk256;

    // Hard stop so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic compareAll(input string phase, input exp_t e);
        checkOutput({phase, ".entry"},      32'(entry),      32'(e.entry));
        checkOutput({phase, ".digit_cnt"},  32'(digit_cnt),  32'(e.cnt));
        checkOutput({phase, ".new_time"},   32'(new_time),   32'(e.nt));
        checkOutput({phase, ".load_time"},  32'(load_time),  32'(e.lt));
        checkOutput({phase, ".load_alarm"}, 32'(load_alarm), 32'(e.la));
        checkOutput({phase, ".entry_err"},  32'(entry_err),  32'(e.er));
    endtask

    function automatic int digitOf(input logic [7:0] code);
        case (code)
            8'h70: return 0;
            8'h69: return 1;
            8'h72: return 2;
            8'h7A: return 3;
            8'h6B: return 4;
            8'h73: return 5;
            8'h74: return 6;
            8'h6C: return 7;
            8'h75: return 8;
            8'h7D: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        m_prev  = 8'h00;
        m_brk   = 1'b0;
        m_entry = 16'h0000;
        m_cnt   = 0;
        m_new   = 16'h0000;
        m_idle  = 0;
    endtask

    // Predict the outputs after one clock edge with the given code applied
    task automatic modelStep(input logic [7:0] code);
        exp_t e;
        bit   mk;
        int   dval;
        int   hrs;
        int   mins;
        e.lt = 1'b0;
        e.la = 1'b0;
        e.er = 1'b0;
        mk = 1'b0;
        if (code != m_prev) begin
            if (m_brk)               m_brk = 1'b0;
            else if (code == 8'hF0)  m_brk = 1'b1;
            else                     mk = 1'b1;
        end
        m_prev = code;
        dval = digitOf(code);
        if (mk) begin
            m_idle = 0;
            if (dval >= 0) begin
                m_entry = {m_entry[11:0], 4'(dval)};
                if (m_cnt < 4) m_cnt++;
            end else if (code == 8'h7C || code == 8'h7B) begin
                if (m_cnt == 0) begin
                    e.er = 1'b1;
                end else begin
                    hrs  = int'(m_entry[15:12]) * 10 + int'(m_entry[11:8]);
                    mins = int'(m_entry[7:4]) * 10 + int'(m_entry[3:0]);
                    if (hrs <= 23 && mins <= 59) begin
                        m_new = m_entry;
                        if (code == 8'h7C) e.la = 1'b1;
                        else               e.lt = 1'b1;
                    end else begin
                        e.er = 1'b1;
                    end
                    m_entry = 16'h0000;
                    m_cnt   = 0;
                end
            end
        end else if (m_cnt == 0) begin
            m_idle = 0;
        end else begin
`ifdef KBD_ENTRY_TIMEOUT_EN
            m_idle++;
            if (m_idle == TB_TIMEOUT) begin
                m_entry = 16'h0000;
                m_cnt   = 0;
                m_idle  = 0;
            end
`endif
        end
        e.entry = m_entry;
        e.cnt   = 3'(m_cnt);
        e.nt    = m_new;
        sb.push_back(e);
    endtask

    // Drive one code for one cycle, queue the prediction, check after the edge
    task automatic applyStimulus(input logic [7:0] code, input string tag);
        exp_t e;
        @(negedge clk256);
        key_code = code;
        modelStep(code);
        @(posedge clk256);
        #1;
        e = sb.pop_front();
        compareAll(tag, e);
    endtask

    task automatic pressKey(input logic [7:0] code, input string tag);
        applyStimulus(code, tag);
        applyStimulus(8'hF0, {tag, ".brk"});
        applyStimulus(code, {tag, ".rel"});
    endtask

    initial begin
        exp_t zero;
        zero.entry = 16'h0000;
        zero.cnt   = 3'd0;
        zero.nt    = 16'h0000;
        zero.lt    = 1'b0;
        zero.la    = 1'b0;
        zero.er    = 1'b0;

        reset    = 1'b1;
        key_code = 8'h00;
        modelReset();
        repeat (2) @(posedge clk256);
        #1;
        compareAll("reset", zero);
        @(negedge clk256);
        reset = 1'b0;

        // 1,2,5,0 then '-' : clock time 12:50
        pressKey(8'h69, "t1.d1");
        pressKey(8'h72, "t1.d2");
        pressKey(8'h73, "t1.d5");
        pressKey(8'h70, "t1.d0");
        pressKey(8'h7B, "t1.minus");

        // 7,5,3,0 then '*' : 75 hours rejected
        pressKey(8'h6C, "t2.d7");
        pressKey(8'h73, "t2.d5");
        pressKey(8'h7A, "t2.d3");
        pressKey(8'h70, "t2.d0");
        pressKey(8'h7C, "t2.star");

        // Typematic KP_4 then its break
        for (int i = 0; i < 10; i++) applyStimulus(8'h6B, "t3.typematic");
        applyStimulus(8'hF0, "t3.brk");
        applyStimulus(8'h6B, "t3.rel");

        // Five digits overflow the window, then '-'
        pressKey(8'h69, "t4.d1");
        pressKey(8'h72, "t4.d2");
        pressKey(8'h7A, "t4.d3");
        pressKey(8'h6B, "t4.d4");
        pressKey(8'h73, "t4.d5");
        pressKey(8'h7B, "t4.minus");

        // '*' with nothing typed
        pressKey(8'h7C, "t5.star_empty");

        // Boundary 23:59 accepted as alarm
        pressKey(8'h72, "t6.d2");
        pressKey(8'h7A, "t6.d3");
        pressKey(8'h73, "t6.d5");
        pressKey(8'h7D, "t6.d9");
        pressKey(8'h7C, "t6.star");

        // 24:00 rejected, non-keypad code ignored in between
        pressKey(8'h72, "t7.d2");
        pressKey(8'h1C, "t7.other");
        pressKey(8'h6B, "t7.d4");
        pressKey(8'h70, "t7.d0");
        pressKey(8'h70, "t7.d0b");
        pressKey(8'h7B, "t7.minus");

        // 09:60 rejected (minutes out of range)
        pressKey(8'h70, "t8.d0");
        pressKey(8'h7D, "t8.d9");
        pressKey(8'h74, "t8.d6");
        pressKey(8'h70, "t8.d0b");
        pressKey(8'h7C, "t8.star");

        // Asynchronous reset with three digits pending
        pressKey(8'h69, "t9.d1");
        pressKey(8'h72, "t9.d2");
        pressKey(8'h7A, "t9.d3");
        @(negedge clk256);
        reset = 1'b1;
        #1;
        compareAll("t9.async_reset", zero);
        key_code = 8'h00;
        modelReset();
        @(posedge clk256);
        @(negedge clk256);
        reset = 1'b0;

        // Digit 9 then idle; with the timeout feature the entry is dropped
        applyStimulus(8'h7D, "t10.d9");
        for (int i = 0; i < TB_TIMEOUT + 2; i++) applyStimulus(8'h7D, "t10.idle");
        applyStimulus(8'hF0, "t10.brk");
        applyStimulus(8'h7D, "t10.rel");
        pressKey(8'h7C, "t10.star");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
